kbd_async_fifo: RTL and testbench

KBD_ASYNC_FIFO -- requirements
Module: kbd_async_fifo

---
 rtl/kbd_async_fifo.sv | 139 +++++++++++++
 tb/tb_kbd_async_fifo.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/kbd_async_fifo.sv
// Dual-clock keyboard FIFO: Gray-coded pointers cross between wr_clk and rd_clk,
// with first-word fall-through read data and sticky overflow/underflow flags.
module kbd_async_fifo #(
  parameter int WIDTH       = 8,
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              wr_clk,
  input  logic              reset,
  input  logic              rd_clk,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              we,
  output logic              full,
  output logic              overflow,
  output logic [ADDR_W:0]   wr_level,
  input  logic              poll,
  output logic [WIDTH-1:0]  rd_data,
  output logic              empty,
  output logic              underflow,
  output logic [ADDR_W:0]   rd_level
);

  localparam int PW    = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [PW-1:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_ZERO  = {PW{1'b0}};
  localparam logic [PW-1:0] FULL_MASK = {2'b11, {(ADDR_W-1){1'b0}}};

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [1:0]        wr_rst_r, rd_rst_r;
  logic              wr_rst_s, rd_rst_s;
  logic [WIDTH-1:0]  mem_r [DEPTH];

  logic [PW-1:0]     wr_bin_r, wr_gray_r, wr_bin_next_s, wr_gray_next_s;
  logic [PW-1:0]     rq_sync_r [SYNC_STAGES];
  logic              wr_en_s, full_r, overflow_r;
  logic [PW-1:0]     wr_level_r;

  logic [PW-1:0]     rd_bin_r, rd_gray_r, rd_bin_next_s, rd_gray_next_s;
  logic [PW-1:0]     wq_sync_r [SYNC_STAGES];
  logic              rd_en_s, empty_r, underflow_r;
  logic [PW-1:0]     rd_level_r;

  // Write-domain reset: asserts immediately, releases on a wr_clk edge
  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) wr_rst_r <= 2'b11;
    else       wr_rst_r <= {wr_rst_r[0], 1'b0};
  end

  // Read-domain reset: asserts immediately, releases on an rd_clk edge
  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) rd_rst_r <= 2'b11;
    else       rd_rst_r <= {rd_rst_r[0], 1'b0};
  end

  assign wr_rst_s = wr_rst_r[1];
  assign rd_rst_s = rd_rst_r[1];

  // Write-side next pointer
  always_comb begin
    wr_en_s        = we & ~full_r & ~wr_rst_s;
    wr_bin_next_s  = wr_en_s ? (wr_bin_r + PTR_ONE) : wr_bin_r;
    wr_gray_next_s = bin2gray(wr_bin_next_s);
  end

  // Storage array, written only on wr_clk and never reset
  always_ff @(posedge wr_clk) begin
    if (wr_en_s) mem_r[wr_bin_r[ADDR_W-1:0]] <= wr_data;
  end

  // Write pointer, rd_ptr synchroniser and write-side status
  always_ff @(posedge wr_clk or posedge wr_rst_s) begin
    if (wr_rst_s) begin
      wr_bin_r   <= PTR_ZERO;
      wr_gray_r  <= PTR_ZERO;
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
      wr_level_r <= PTR_ZERO;
      for (int i = 0; i < SYNC_STAGES; i++) rq_sync_r[i] <= PTR_ZERO;
    end else begin
      wr_bin_r     <= wr_bin_next_s;
      wr_gray_r    <= wr_gray_next_s;
      rq_sync_r[0] <= rd_gray_r;
      for (int i = 1; i < SYNC_STAGES; i++) rq_sync_r[i] <= rq_sync_r[i-1];
      // Full when the writer is one lap ahead: top two Gray bits differ
      full_r     <= (wr_gray_next_s == (rq_sync_r[SYNC_STAGES-1] ^ FULL_MASK));
      overflow_r <= overflow_r | (we & full_r);
      wr_level_r <= wr_bin_next_s - gray2bin(rq_sync_r[SYNC_STAGES-1]);
    end
  end

  // Read-side next pointer
  always_comb begin
    rd_en_s        = poll & ~empty_r & ~rd_rst_s;
    rd_bin_next_s  = rd_en_s ? (rd_bin_r + PTR_ONE) : rd_bin_r;
    rd_gray_next_s = bin2gray(rd_bin_next_s);
  end

  // Read pointer, wr_ptr synchroniser and read-side status
  always_ff @(posedge rd_clk or posedge rd_rst_s) begin
    if (rd_rst_s) begin
      rd_bin_r    <= PTR_ZERO;
      rd_gray_r   <= PTR_ZERO;
      empty_r     <= 1'b1;
      underflow_r <= 1'b0;
      rd_level_r  <= PTR_ZERO;
      for (int i = 0; i < SYNC_STAGES; i++) wq_sync_r[i] <= PTR_ZERO;
    end else begin
      rd_bin_r     <= rd_bin_next_s;
      rd_gray_r    <= rd_gray_next_s;
      wq_sync_r[0] <= wr_gray_r;
      for (int i = 1; i < SYNC_STAGES; i++) wq_sync_r[i] <= wq_sync_r[i-1];
      empty_r     <= (rd_gray_next_s == wq_sync_r[SYNC_STAGES-1]);
      underflow_r <= underflow_r | (poll & empty_r);
      rd_level_r  <= gray2bin(wq_sync_r[SYNC_STAGES-1]) - rd_bin_next_s;
    end
  end

  assign full      = full_r;
  assign overflow  = overflow_r;
  assign wr_level  = wr_level_r;
  assign empty     = empty_r;
  assign underflow = underflow_r;
  assign rd_level  = rd_level_r;
  assign rd_data   = empty_r ? {WIDTH{1'b0}} : mem_r[rd_bin_r[ADDR_W-1:0]];

endmodule

// File: tb/tb_kbd_async_fifo.sv
// Scoreboard bench for kbd_async_fifo: directed flag/boundary cases plus a
// randomised two-clock stream.
module tb_kbd_async_fifo;
  localparam int WIDTH  = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int SS     = 2;

  logic              wr_clk = 1'b0, rd_clk = 1'b0, reset = 1'b1;
  logic              we = 1'b0, poll = 1'b0;
  logic [WIDTH-1:0]  wr_data = 8'h00;
  logic              full, overflow, empty, underflow;
  logic [ADDR_W:0]   wr_level, rd_level;
  logic [WIDTH-1:0]  rd_data;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] sb[$];

  kbd_async_fifo #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .SYNC_STAGES(SS)) dut (
    .wr_clk(wr_clk), .reset(reset), .rd_clk(rd_clk),
    .wr_data(wr_data), .we(we), .full(full), .overflow(overflow), .wr_level(wr_level),
    .poll(poll), .rd_data(rd_data), .empty(empty), .underflow(underflow), .rd_level(rd_level)
  );

  always #10 wr_clk = ~wr_clk;
  always #15 rd_clk = ~rd_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr_word(input logic [WIDTH-1:0] d, input bit expect_accept);
    @(negedge wr_clk);
    wr_data = d;
    we      = 1'b1;
    if (expect_accept) sb.push_back(d);
    @(posedge wr_clk);
    #1;
    we = 1'b0;
  endtask

  // Wait (bounded) for data, compare the head against the scoreboard, then pop
  task automatic rd_word(input int bound);
    int n = 0;
    @(negedge rd_clk);
    while (empty && n < bound) begin
      @(negedge rd_clk);
      n++;
    end
    if (empty) begin
      check_val("rd_timeout", {31'b0, empty}, 32'd0);
    end else begin
      if (sb.size() == 0) check_val("sb_underrun", 32'(sb.size()), 32'd1);
      else                check_val("rd_data", {24'b0, rd_data}, {24'b0, sb.pop_front()});
      poll = 1'b1;
      @(posedge rd_clk);
      #1;
      poll = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    // Reset state, checked while reset is held and after release
    #25;
    check_val("rst_full",     {31'b0, full},  32'd0);
    check_val("rst_empty",    {31'b0, empty}, 32'd1);
    check_val("rst_rd_data",  {24'b0, rd_data}, 32'd0);
    check_val("rst_wr_level", {27'b0, wr_level}, 32'd0);
    check_val("rst_rd_level", {27'b0, rd_level}, 32'd0);
    @(negedge wr_clk);
    reset = 1'b0;
    repeat (4) @(negedge rd_clk);
    check_val("rst_overflow",  {31'b0, overflow},  32'd0);
    check_val("rst_underflow", {31'b0, underflow}, 32'd0);

    // Single word: visibility latency and fall-through data
    wr_word(8'hA5, 1'b1);
    lat = 99;
    for (int i = 1; i <= 8; i++) begin
      @(posedge rd_clk);
      #1;
      if (!empty) begin
        lat = i;
        break;
      end
    end
    check_val("vis_latency_ok", {31'b0, (lat <= SS + 2)}, 32'd1);
    check_val("vis_data", {24'b0, rd_data}, 32'h0000_00A5);
    rd_word(20);
    check_val("pop_empty", {31'b0, empty}, 32'd1);
    check_val("pop_rd_data", {24'b0, rd_data}, 32'd0);

    // Poll while empty
    @(negedge rd_clk);
    poll = 1'b1;
    @(posedge rd_clk);
    #1;
    poll = 1'b0;
    check_val("uf_flag", {31'b0, underflow}, 32'd1);
    check_val("uf_empty", {31'b0, empty}, 32'd1);
    check_val("uf_rd_data", {24'b0, rd_data}, 32'd0);
    check_val("uf_rd_level", {27'b0, rd_level}, 32'd0);

    // Fill to capacity, then one dropped write
    for (int i = 0; i < DEPTH; i++) wr_word(8'(i), 1'b1);
    check_val("fill_full", {31'b0, full}, 32'd1);
    check_val("fill_wr_level", {27'b0, wr_level}, 32'd16);
    check_val("fill_no_ovf", {31'b0, overflow}, 32'd0);
    wr_word(8'hFF, 1'b0);
    check_val("ovf_flag", {31'b0, overflow}, 32'd1);
    check_val("ovf_full", {31'b0, full}, 32'd1);
    check_val("ovf_wr_level", {27'b0, wr_level}, 32'd16);
    repeat (6) @(negedge rd_clk);
    check_val("fill_rd_level", {27'b0, rd_level}, 32'd16);
    for (int i = 0; i < DEPTH; i++) rd_word(50);
    repeat (8) @(negedge rd_clk);
    check_val("drain_empty", {31'b0, empty}, 32'd1);
    check_val("drain_rd_data", {24'b0, rd_data}, 32'd0);
    repeat (6) @(negedge wr_clk);
    check_val("drain_full", {31'b0, full}, 32'd0);
    check_val("drain_wr_level", {27'b0, wr_level}, 32'd0);

    // Random two-clock stream; pointers wrap several times
    fork
      begin
        for (int k = 0; k < 100; k++) begin
          int n = 0;
          repeat ($urandom_range(0, 3)) @(negedge wr_clk);
          while (full && n < 500) begin
            @(negedge wr_clk);
            n++;
          end
          if (full) check_val("wr_timeout", {31'b0, full}, 32'd0);
          else      wr_word(8'($urandom), 1'b1);
        end
      end
      begin
        for (int r = 0; r < 100; r++) begin
          repeat ($urandom_range(0, 3)) @(negedge rd_clk);
          rd_word(400);
        end
      end
    join
    repeat (8) @(negedge rd_clk);
    check_val("stream_empty", {31'b0, empty}, 32'd1);
    check_val("stream_rd_level", {27'b0, rd_level}, 32'd0);

    // Mid-stream reset discards queued data
    for (int i = 0; i < 5; i++) wr_word(8'(8'h50 + i), 1'b1);
    @(negedge wr_clk);
    reset = 1'b1;
    #2;
    check_val("mid_rst_empty", {31'b0, empty}, 32'd1);
    check_val("mid_rst_full", {31'b0, full}, 32'd0);
    check_val("mid_rst_rd_data", {24'b0, rd_data}, 32'd0);
    check_val("mid_rst_wr_level", {27'b0, wr_level}, 32'd0);
    @(negedge wr_clk);
    reset = 1'b0;
    sb.delete();
    repeat (4) @(negedge rd_clk);
    check_val("post_rst_ovf", {31'b0, overflow}, 32'd0);
    check_val("post_rst_uf", {31'b0, underflow}, 32'd0);
    check_val("post_rst_empty", {31'b0, empty}, 32'd1);
    wr_word(8'h3C, 1'b1);
    rd_word(50);
    repeat (8) @(negedge rd_clk);
    check_val("post_rst_drain", {31'b0, empty}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
